// File: rtl/alu_result_checker.sv
// alu_result_checker: taps the ALU input stream, recomputes the golden result in a
// pipeline matched to the ALU latency and compares it with the ALU output.
// Reports per-compare pass/fail, saturating pass/fail/illegal counters and a sticky
// error flag. Define ALU_CHK_CAPTURE_EN to keep the first-fail capture registers
// (ff_*); without it those outputs are tied to zero.
module alu_result_checker #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [5:0]       in_opsel,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [31:0]      alu_out,
  output logic             chk_valid,
  output logic             chk_fail,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] ill_cnt,
  output logic [5:0]       ff_opsel,
  output logic [31:0]      ff_a,
  output logic [31:0]      ff_b,
  output logic [31:0]      ff_exp,
  output logic [31:0]      ff_act
);

  localparam int unsigned LAST = ALU_LAT - 1;

  logic signed [31:0] sa, sb;
  logic               gold_legal_c;
  logic [31:0]        gold_res_c;
  logic               done_c, mism_c, ill_c;

  logic             pv_q   [ALU_LAT];
  logic [31:0]      pexp_q [ALU_LAT];

  logic             chk_valid_q, chk_valid_d;
  logic             chk_fail_q, chk_fail_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, ill_q, ill_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign sa = $signed(in_a);
  assign sb = $signed(in_b);

  // Golden ALU model on the sampled inputs; flags opcodes outside the legal set.
  always_comb begin
    gold_legal_c = 1'b1;
    gold_res_c   = 32'h0;
    case (in_opsel)
      6'h00: gold_res_c = in_a + in_b;
      6'h01: gold_res_c = in_a - in_b;
      6'h04: gold_res_c = in_a & in_b;
      6'h05: gold_res_c = in_a | in_b;
      6'h06: gold_res_c = in_a ^ in_b;
      6'h0B: gold_res_c = {in_b[15:0], 16'h0};
      6'h0C: gold_res_c = ~(in_a & in_b);
      6'h0D: gold_res_c = ~(in_a | in_b);
      6'h0E: gold_res_c = ~(in_a ^ in_b);
      6'h10: gold_res_c = 32'h0;
      6'h11: gold_res_c = 32'(sa == sb);
      6'h12: gold_res_c = 32'(sa < sb);
      6'h13: gold_res_c = 32'(sa <= sb);
      6'h15: gold_res_c = 32'(sa == 32'sd0);
      6'h16: gold_res_c = 32'(sa < 32'sd0);
      6'h17: gold_res_c = 32'(sa <= 32'sd0);
      6'h18: gold_res_c = 32'h1;
      6'h19: gold_res_c = 32'(sa != sb);
      6'h1A: gold_res_c = 32'(sa >= sb);
      6'h1B: gold_res_c = 32'(sa > sb);
      6'h1D: gold_res_c = 32'(sa != 32'sd0);
      6'h1E: gold_res_c = 32'(sa >= 32'sd0);
      6'h1F: gold_res_c = 32'(sa > 32'sd0);
      default: gold_legal_c = 1'b0;
    endcase
  end

  // Delay line carrying expected result and valid to the ALU output time; not cleared by clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ALU_LAT; i++) begin
        pv_q[i]   <= 1'b0;
        pexp_q[i] <= 32'h0;
      end
    end else begin
      pv_q[0]   <= in_valid & gold_legal_c;
      pexp_q[0] <= gold_res_c;
      for (int unsigned i = 1; i < ALU_LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        pexp_q[i] <= pexp_q[i-1];
      end
    end
  end

  assign done_c = pv_q[LAST];
  assign mism_c = done_c && (alu_out != pexp_q[LAST]);
  assign ill_c  = in_valid && !gold_legal_c;

  // Next-state for compare result, counters and sticky flag; clr overrides everything.
  always_comb begin
    chk_valid_d = done_c;
    chk_fail_d  = mism_c;
    err_d       = err_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    ill_d       = ill_q;
    if (mism_c) begin
      fail_d = sat_inc(fail_q);
      err_d  = 1'b1;
    end else if (done_c) begin
      pass_d = sat_inc(pass_q);
    end
    if (ill_c) ill_d = sat_inc(ill_q);
    if (clr) begin
      chk_valid_d = 1'b0;
      chk_fail_d  = 1'b0;
      err_d       = 1'b0;
      pass_d      = '0;
      fail_d      = '0;
      ill_d       = '0;
    end
  end

  // Status and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_valid_q <= 1'b0;
      chk_fail_q  <= 1'b0;
      err_q       <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
      ill_q       <= '0;
    end else begin
      chk_valid_q <= chk_valid_d;
      chk_fail_q  <= chk_fail_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      ill_q       <= ill_d;
    end
  end

  assign chk_valid  = chk_valid_q;
  assign chk_fail   = chk_fail_q;
  assign err_sticky = err_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign ill_cnt    = ill_q;

`ifdef ALU_CHK_CAPTURE_EN
  logic [5:0]  pop_q [ALU_LAT];
  logic [31:0] pa_q  [ALU_LAT];
  logic [31:0] pb_q  [ALU_LAT];
  logic [5:0]  ff_opsel_q;
  logic [31:0] ff_a_q, ff_b_q, ff_exp_q, ff_act_q;
  logic        cap_load_c;

  // Operand delay line so the failing transaction can be recorded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ALU_LAT; i++) begin
        pop_q[i] <= 6'h0;
        pa_q[i]  <= 32'h0;
        pb_q[i]  <= 32'h0;
      end
    end else begin
      pop_q[0] <= in_opsel;
      pa_q[0]  <= in_a;
      pb_q[0]  <= in_b;
      for (int unsigned i = 1; i < ALU_LAT; i++) begin
        pop_q[i] <= pop_q[i-1];
        pa_q[i]  <= pa_q[i-1];
        pb_q[i]  <= pb_q[i-1];
      end
    end
  end

  // Only the first mismatch since reset/clr is captured; err_sticky marks capture as full.
  assign cap_load_c = mism_c && !err_q && !clr;

  // First-fail capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff_opsel_q <= 6'h0;
      ff_a_q     <= 32'h0;
      ff_b_q     <= 32'h0;
      ff_exp_q   <= 32'h0;
      ff_act_q   <= 32'h0;
    end else if (clr) begin
      ff_opsel_q <= 6'h0;
      ff_a_q     <= 32'h0;
      ff_b_q     <= 32'h0;
      ff_exp_q   <= 32'h0;
      ff_act_q   <= 32'h0;
    end else if (cap_load_c) begin
      ff_opsel_q <= pop_q[LAST];
      ff_a_q     <= pa_q[LAST];
      ff_b_q     <= pb_q[LAST];
      ff_exp_q   <= pexp_q[LAST];
      ff_act_q   <= alu_out;
    end
  end

  assign ff_opsel = ff_opsel_q;
  assign ff_a     = ff_a_q;
  assign ff_b     = ff_b_q;
  assign ff_exp   = ff_exp_q;
  assign ff_act   = ff_act_q;
`else
  assign ff_opsel = 6'h0;
  assign ff_a     = 32'h0;
  assign ff_b     = 32'h0;
  assign ff_exp   = 32'h0;
  assign ff_act   = 32'h0;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker with a two-cycle ALU model feeding alu_out.
module tb_alu_result_checker;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_opsel = 6'h0;
  logic [31:0] in_a = 32'h0, in_b = 32'h0;
  logic [31:0] alu_out = 32'h0;
  logic        chk_valid, chk_fail, err_sticky;
  logic [15:0] pass_cnt, fail_cnt, ill_cnt;
  logic [5:0]  ff_opsel;
  logic [31:0] ff_a, ff_b, ff_exp, ff_act;

  logic        alu_bad = 1'b0;
  logic [31:0] alu_s1 = 32'h0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int   due;
    logic fl;
    logic drop;
  } sb_t;
  sb_t sb[$];

  alu_result_checker #(.ALU_LAT(LAT), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid),
    .in_opsel(in_opsel), .in_a(in_a), .in_b(in_b), .alu_out(alu_out),
    .chk_valid(chk_valid), .chk_fail(chk_fail), .err_sticky(err_sticky),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .ill_cnt(ill_cnt),
    .ff_opsel(ff_opsel), .ff_a(ff_a), .ff_b(ff_b), .ff_exp(ff_exp), .ff_act(ff_act)
  );

  always #5 clk = ~clk;

  function automatic logic tb_legal(input logic [5:0] op);
    case (op)
      6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
      6'h10, 6'h11, 6'h12, 6'h13, 6'h15, 6'h16, 6'h17, 6'h18, 6'h19,
      6'h1A, 6'h1B, 6'h1D, 6'h1E, 6'h1F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] tb_gold(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb_;
    sa = int'(a);
    sb_ = int'(b);
    case (op)
      6'h00: return a + b;
      6'h01: return a - b;
      6'h04: return a & b;
      6'h05: return a | b;
      6'h06: return a ^ b;
      6'h0B: return b << 16;
      6'h0C: return ~(a & b);
      6'h0D: return ~(a | b);
      6'h0E: return ~(a ^ b);
      6'h11: return (sa == sb_) ? 32'd1 : 32'd0;
      6'h12: return (sa < sb_) ? 32'd1 : 32'd0;
      6'h13: return (sa <= sb_) ? 32'd1 : 32'd0;
      6'h15: return (sa == 0) ? 32'd1 : 32'd0;
      6'h16: return (sa < 0) ? 32'd1 : 32'd0;
      6'h17: return (sa <= 0) ? 32'd1 : 32'd0;
      6'h18: return 32'd1;
      6'h19: return (sa != sb_) ? 32'd1 : 32'd0;
      6'h1A: return (sa >= sb_) ? 32'd1 : 32'd0;
      6'h1B: return (sa > sb_) ? 32'd1 : 32'd0;
      6'h1D: return (sa != 0) ? 32'd1 : 32'd0;
      6'h1E: return (sa >= 0) ? 32'd1 : 32'd0;
      6'h1F: return (sa > 0) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Two-stage ALU model; alu_bad forces the result to zero to provoke a mismatch.
  always @(posedge clk) begin
    alu_s1  <= alu_bad ? 32'h0 : tb_gold(in_opsel, in_a, in_b);
    alu_out <= alu_s1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every cycle either the due entry is checked or chk_valid must be low.
  always begin
    sb_t e;
    @(posedge clk);
    #2;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL sb_latency due %0d now %0d", e.due, cyc);
      end else if (e.drop) begin
        if (chk_valid !== 1'b0) begin
          errors++;
          $display("FAIL sb_dropped chk_valid got %b exp 0", chk_valid);
        end
      end else if (chk_valid !== 1'b1 || chk_fail !== e.fl) begin
        errors++;
        $display("FAIL sb_compare cyc %0d chk_valid/chk_fail got %b/%b exp 1/%b", cyc, chk_valid, chk_fail, e.fl);
      end
    end else begin
      checks++;
      if (chk_valid !== 1'b0) begin
        errors++;
        $display("FAIL sb_unexpected cyc %0d chk_valid got %b exp 0", cyc, chk_valid);
      end
    end
  end

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic bad, input logic drop);
    sb_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_opsel = op;
    in_a = a;
    in_b = b;
    alu_bad = bad;
    if (tb_legal(op)) begin
      e.due = cyc + 1 + LAT;
      e.fl = bad;
      e.drop = drop;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      alu_bad = 1'b0;
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic check_cnts(input string tag, input int p, input int f, input int il);
    checks++;
    if (pass_cnt !== 16'(p) || fail_cnt !== 16'(f) || ill_cnt !== 16'(il)) begin
      errors++;
      $display("FAIL %s counters pass/fail/ill got %0d/%0d/%0d exp %0d/%0d/%0d",
               tag, pass_cnt, fail_cnt, ill_cnt, p, f, il);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({chk_valid, chk_fail, err_sticky, pass_cnt, fail_cnt, ill_cnt} !== 51'h0 ||
        {ff_opsel, ff_a, ff_b, ff_exp, ff_act} !== 134'h0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero exp all zero (pass %0d fail %0d ill %0d)", pass_cnt, fail_cnt, ill_cnt);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_add();
    drive(6'h00, 32'd5, 32'd5, 1'b0, 1'b0);
    idle(LAT + 3);
    check_cnts("add", 1, 0, 0);
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL add_err_sticky got %b exp 0", err_sticky);
    end
  endtask

  task automatic test_mismatch();
    logic [37:0]  exp_id;
    logic [63:0]  exp_res;
    do_clr();
    drive(6'h01, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
    idle(LAT + 3);
    check_cnts("mism1", 0, 1, 0);
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL mism_err_sticky got %b exp 1", err_sticky);
    end
`ifdef ALU_CHK_CAPTURE_EN
    exp_id  = {6'h01, 32'hFFFF_FFFF};
    exp_res = {32'hFFFF_FFFA, 32'h0};
`else
    exp_id  = 38'h0;
    exp_res = 64'h0;
`endif
    checks++;
    if ({ff_opsel, ff_a} !== exp_id || ff_b !== (exp_id == 38'h0 ? 32'h0 : 32'd5) ||
        {ff_exp, ff_act} !== exp_res) begin
      errors++;
      $display("FAIL mism_capture got op %h a %h b %h exp %h act %h required %h/%h", ff_opsel, ff_a, ff_b, ff_exp, ff_act, exp_id, exp_res);
    end
    drive(6'h00, 32'd1, 32'd1, 1'b1, 1'b0);
    idle(LAT + 3);
    check_cnts("mism2", 0, 2, 0);
    checks++;
    if ({ff_opsel, ff_a} !== exp_id || {ff_exp, ff_act} !== exp_res) begin
      errors++;
      $display("FAIL mism_capture_hold got op %h exp %h act %h required %h/%h", ff_opsel, ff_exp, ff_act, exp_id, exp_res);
    end
  endtask

  task automatic test_back_to_back();
    do_clr();
    drive(6'h12, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0);
    drive(6'h1F, 32'd0, 32'd9, 1'b0, 1'b0);
    drive(6'h0B, 32'd7, 32'd5, 1'b0, 1'b0);
    drive(6'h0D, 32'h0F0F_0000, 32'h00FF_00FF, 1'b0, 1'b0);
    drive(6'h1A, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
    idle(LAT + 3);
    check_cnts("b2b", 5, 0, 0);
  endtask

  task automatic test_illegal();
    do_clr();
    drive(6'h00, 32'd2, 32'd3, 1'b0, 1'b0);
    idle(1);
    drive(6'h02, 32'd1, 32'd1, 1'b0, 1'b0);
    idle(LAT + 3);
    check_cnts("illegal", 1, 0, 1);
  endtask

  task automatic test_clr_race();
    do_clr();
    drive(6'h00, 32'd3, 32'd4, 1'b0, 1'b1);
    drive(6'h05, 32'h10, 32'h01, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    idle(LAT + 3);
    check_cnts("clr_race", 1, 0, 0);
  endtask

  task automatic test_reset_midstream();
    do_clr();
    drive(6'h00, 32'd1, 32'd2, 1'b0, 1'b0);
    drive(6'h01, 32'd9, 32'd2, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    alu_bad = 1'b0;
    reset_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({chk_valid, chk_fail, err_sticky, pass_cnt, fail_cnt, ill_cnt} !== 51'h0 ||
        {ff_opsel, ff_a, ff_b, ff_exp, ff_act} !== 134'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got pass %0d fail %0d err %b exp all zero", pass_cnt, fail_cnt, err_sticky);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(LAT + 4);
    check_cnts("rst_mid", 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mismatch();
    test_back_to_back();
    test_illegal();
    test_clr_race();
    test_reset_midstream();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d entries exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
